depth_sprite: RTL and testbench
===============================

# depth_sprite

Parametrised, depth-scaled sprite renderer that succeeds the single-sprite ball renderer in the graphics pipeline. It maps a sprite centre (x, y) and depth z to one of NUM_ZONES pre-scaled images held in a single shared ROM. It issues ROM addresses for each scanned pixel and returns a latency-aligned, colour-keyed pixel. New positions are double-buffered and committed only at frame start, so the sprite never tears mid-frame.

## Interface
- NUM_ZONES, 20: number of depth zones / scaled images
- ZONE_DEPTH, 50: z units per zone
- COORD_W, 16: coordinate width (x, y, z, pixel)
- ADDR_W, 16: ROM address width
- DATA_W, 24: pixel width, {R[23:16], G[15:8], B[7:0]}
- ROM_LAT, 1: ROM read latency in cycles, legal range 1..3
- KEY_THRESH, 8'h90: green-channel threshold; the pixel is opaque when G >= threshold

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- x_loc, y_loc, z_loc  in  COORD_W each  requested sprite centre and depth
- loc_valid  in  1  one-cycle strobe that captures x/y/z into the shadow registers
- frame_start  in  1  one-cycle strobe at the start of each frame
- pixel_x, pixel_y  in  COORD_W each  current scan position
- pixel_valid  in  1  scan position is valid this cycle
- rom_addr  out  ADDR_W  address to the shared sprite ROM
- rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_addr
- color  out  DATA_W  sprite pixel, or 0 when transparent or outside the box
- color_valid  out  1  pixel_valid delayed to align with color
- busy  out  1  zone calculation in progress

## Operation
- Shadow capture. loc_valid latches x, y and z into the shadow registers and starts the zone FSM.
- Zone FSM states: IDLE, CALC, READY.
  - IDLE -> CALC on loc_valid; the remainder is initialised to z and the zone counter to 0.
  - In CALC, each cycle with remainder >= ZONE_DEPTH and zone < NUM_ZONES-1: subtract ZONE_DEPTH and increment zone. Otherwise go to READY.
  - READY -> IDLE when frame_start commits the shadow into the active geometry.
  - loc_valid during CALC or READY restarts CALC with the new values.
- Commit rule. frame_start in any state other than READY leaves the active geometry unchanged.
- Active geometry, computed from the committed zone z_i:
  - S = SIZE[z_i], H = S>>1.
  - left = x − H, top = y − H, both signed COORD_W+1 bits, so negative values are legal.
- Inside test: left <= px < left+S and top <= py < top+S, evaluated with signed compares. The box is exactly S×S pixels.
- Row base register, updated when pixel_y differs from the registered pixel_y:
  - new py == top: row_base = BASE[z_i]
  - top < py < top+S: row_base += S
  - otherwise: row_base = BASE[z_i]
  - Rows are assumed to increase monotonically within a frame.
- Address: rom_addr = row_base + (px − left) when inside, otherwise BASE[z_i].
- Output stage:
  - The inside flag is delayed ROM_LAT cycles to align with rom_data.
  - active = inside_d && rom_data[15:8] >= KEY_THRESH.
  - color is registered: rom_data when active, else 0.

## Timing
- Reset values:
  - color=0, color_valid=0, busy=0, rom_addr=0, FSM=IDLE
  - committed zone=0 and x=y=0; row_base=0
- busy=1 exactly while the FSM is in CALC. CALC takes min(z/ZONE_DEPTH, NUM_ZONES-1)+1 cycles.
- Pipeline latency:
  - pixel_x/pixel_y to rom_addr: 1 cycle (registered).
  - rom_addr to color/color_valid: ROM_LAT+1 cycles.
  - Total: ROM_LAT+2 cycles.
- loc_valid and frame_start in the same cycle: the commit uses the previous READY shadow, and the new capture starts CALC.
- rst asserted mid-frame clears the pipeline immediately. Output is 0 until the first commit.
- z >= NUM_ZONES*ZONE_DEPTH saturates to zone NUM_ZONES-1.

## Structure
- Package depth_sprite_pkg holds:
  - SIZE[] default {69,60,53,48,43,39,36,33,31,29,27,26,24,23,22,21,20,19,18,17}.
  - BASE[], computed by a constant function as the prefix sum of SIZE².
  - The FSM state enum.
- Sub-module depth_sprite_zone_calc holds the shadow registers and the zone FSM. The top level contains the geometry, address and output pipeline.

## Test plan
1. Load x=320, y=240, z=0, then frame_start, then scan rows 206..274 at ROM_LAT=1.
   - Box spans x 286..354.
   - First rom_addr is 0; the first address of the second row is 69.
   - color appears 3 cycles after the matching pixel.
2. Load z=975.
   - busy is high for 20 cycles; zone saturates at 19 (S=17).
   - rom_addr equals BASE[19] at the box's top-left corner.
3. Load z=120 with no frame_start.
   - Geometry and colors stay at the old zone.
   - After frame_start, S=53 takes effect on the next frame.
4. Load x=10, y=10, z=0, giving left=−24.
   - px=0 is inside with address row_base+24.
   - px=45 is outside; no wraparound pixels appear at the far right.
5. Return rom_data G=8'h8F, then G=8'h90.
   - color is 0 for the first, then equals rom_data for the second.
   - Repeat with ROM_LAT=3 and check alignment shifts by 2 cycles.
6. Pulse rst mid-scan.
   - All outputs are 0 on the next edge.
   - No sprite appears until the next load and frame_start.

Source files
------------

// File: rtl/depth_sprite_pkg.sv
// rtl/depth_sprite_pkg.sv - size/base tables and zone FSM type for depth_sprite
package depth_sprite_pkg;

  localparam int MAX_ZONES = 20;

  typedef logic [0:MAX_ZONES-1][15:0] zone_tbl_t;

  localparam zone_tbl_t SIZE = '{16'd69, 16'd60, 16'd53, 16'd48, 16'd43, 16'd39, 16'd36,
                                 16'd33, 16'd31, 16'd29, 16'd27, 16'd26, 16'd24, 16'd23,
                                 16'd22, 16'd21, 16'd20, 16'd19, 16'd18, 16'd17};

  // Images are packed back to back in the ROM, so each base is the running sum of S*S.
  function automatic zone_tbl_t calc_base(zone_tbl_t sizes);
    zone_tbl_t b;
    int        acc;
    acc = 0;
    for (int i = 0; i < MAX_ZONES; i++) begin
      b[i] = 16'(acc);
      acc += int'(sizes[i]) * int'(sizes[i]);
    end
    return b;
  endfunction

  localparam zone_tbl_t BASE = calc_base(SIZE);

  typedef enum logic [1:0] {ZS_IDLE, ZS_CALC, ZS_READY} zone_state_t;

endpackage

// File: rtl/depth_sprite_zone_calc.sv
// rtl/depth_sprite_zone_calc.sv - shadow position registers, zone search FSM and frame commit
module depth_sprite_zone_calc
  import depth_sprite_pkg::*;
#(
  parameter int NUM_ZONES  = 20,
  parameter int ZONE_DEPTH = 50,
  parameter int COORD_W    = 16,
  parameter int ZW         = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_z,
  input  logic               i_loc_valid,
  input  logic               i_frame_start,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [ZW-1:0]      o_zone,
  output logic               o_committed,
  output logic               o_busy
);

  zone_state_t        r_state;
  logic [COORD_W-1:0] r_sx;
  logic [COORD_W-1:0] r_sy;
  logic [COORD_W-1:0] r_rem;
  logic [ZW-1:0]      r_zone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ZS_IDLE;
      r_sx        <= '0;
      r_sy        <= '0;
      r_rem       <= '0;
      r_zone      <= '0;
      o_x         <= '0;
      o_y         <= '0;
      o_zone      <= '0;
      o_committed <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      if (i_frame_start && r_state == ZS_READY) begin
        o_x         <= r_sx;
        o_y         <= r_sy;
        o_zone      <= r_zone;
        o_committed <= 1'b1;
        r_state     <= ZS_IDLE;
      end
      // A fresh capture wins over the commit's IDLE transition; the commit above still sees the old shadow.
      if (i_loc_valid) begin
        r_sx    <= i_x;
        r_sy    <= i_y;
        r_rem   <= i_z;
        r_zone  <= '0;
        r_state <= ZS_CALC;
        o_busy  <= 1'b1;
      end else if (r_state == ZS_CALC) begin
        if (r_rem >= COORD_W'(ZONE_DEPTH) && r_zone < ZW'(NUM_ZONES - 1)) begin
          r_rem  <= r_rem - COORD_W'(ZONE_DEPTH);
          r_zone <= r_zone + 1'b1;
        end else begin
          r_state <= ZS_READY;
          o_busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/depth_sprite.sv
// rtl/depth_sprite.sv - depth-scaled sprite renderer: box geometry, ROM addressing, colour-keyed output
module depth_sprite
  import depth_sprite_pkg::*;
#(
  parameter int         NUM_ZONES  = 20,
  parameter int         ZONE_DEPTH = 50,
  parameter int         COORD_W    = 16,
  parameter int         ADDR_W     = 16,
  parameter int         DATA_W     = 24,
  parameter int         ROM_LAT    = 1,
  parameter logic [7:0] KEY_THRESH = 8'h90
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x_loc,
  input  logic [COORD_W-1:0] y_loc,
  input  logic [COORD_W-1:0] z_loc,
  input  logic               loc_valid,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               pixel_valid,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  color,
  output logic               color_valid,
  output logic               busy
);

  localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int SW = COORD_W + 2;

  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;
  logic [ZW-1:0]      w_zone;
  logic               w_committed;

  depth_sprite_zone_calc #(
    .NUM_ZONES  (NUM_ZONES),
    .ZONE_DEPTH (ZONE_DEPTH),
    .COORD_W    (COORD_W),
    .ZW         (ZW)
  ) u_zone_calc (
    .clk           (clk),
    .rst           (rst),
    .i_x           (x_loc),
    .i_y           (y_loc),
    .i_z           (z_loc),
    .i_loc_valid   (loc_valid),
    .i_frame_start (frame_start),
    .o_x           (w_cx),
    .o_y           (w_cy),
    .o_zone        (w_zone),
    .o_committed   (w_committed),
    .o_busy        (busy)
  );

  logic signed [SW-1:0] w_size;
  logic signed [SW-1:0] w_left;
  logic signed [SW-1:0] w_top;
  logic signed [SW-1:0] w_px;
  logic signed [SW-1:0] w_py;
  logic [ADDR_W-1:0]    w_base;
  logic [ADDR_W-1:0]    w_col;
  logic [ADDR_W-1:0]    w_row_base;
  logic [ADDR_W-1:0]    r_row_base;
  logic [COORD_W-1:0]   r_py;
  logic                 r_py_vld;
  logic                 w_inside;
  logic                 w_new_row;
  logic [ROM_LAT:0]     r_ins_d;
  logic [ROM_LAT:0]     r_vld_d;

  assign w_size = SW'(SIZE[w_zone]);
  assign w_base = ADDR_W'(BASE[w_zone]);
  // One spare bit beyond sign keeps left+S from overflowing near the top of the coordinate range.
  assign w_left = $signed({2'b00, w_cx}) - (w_size >>> 1);
  assign w_top  = $signed({2'b00, w_cy}) - (w_size >>> 1);
  assign w_px   = $signed({2'b00, pixel_x});
  assign w_py   = $signed({2'b00, pixel_y});
  assign w_col  = ADDR_W'(w_px - w_left);

  assign w_inside = pixel_valid && w_committed &&
                    (w_px >= w_left) && (w_px < w_left + w_size) &&
                    (w_py >= w_top)  && (w_py < w_top + w_size);

  assign w_new_row = pixel_valid && (!r_py_vld || pixel_y != r_py);

  always_comb begin
    w_row_base = r_row_base;
    if (w_new_row) begin
      if (w_py > w_top && w_py < w_top + w_size) begin
        w_row_base = r_row_base + ADDR_W'(w_size);
      end else begin
        w_row_base = w_base;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_base  <= '0;
      r_py        <= '0;
      r_py_vld    <= 1'b0;
      rom_addr    <= '0;
      r_ins_d     <= '0;
      r_vld_d     <= '0;
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      r_row_base <= w_row_base;
      if (pixel_valid) begin
        r_py     <= pixel_y;
        r_py_vld <= 1'b1;
      end
      rom_addr <= w_inside ? (w_row_base + w_col) : w_base;
      // Stage [ROM_LAT] lines up with rom_data for the address issued ROM_LAT cycles earlier.
      r_ins_d     <= {r_ins_d[ROM_LAT-1:0], w_inside};
      r_vld_d     <= {r_vld_d[ROM_LAT-1:0], pixel_valid};
      color       <= (r_ins_d[ROM_LAT] && rom_data[15:8] >= KEY_THRESH) ? rom_data : '0;
      color_valid <= r_vld_d[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_depth_sprite.sv
// tb/tb_depth_sprite.sv - randomized scoreboard bench for depth_sprite at ROM latencies 1 and 3
module tb_depth_sprite;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x_loc = '0, y_loc = '0, z_loc = '0, pixel_x = '0, pixel_y = '0;
  logic        loc_valid = 1'b0, frame_start = 1'b0, pixel_valid = 1'b0;
  logic [15:0] addr1, addr3;
  logic [23:0] rd1, rd3, col1, col3, r3a, r3b, r3c;
  logic        cv1, cv3, busy1, busy3;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {logic [23:0] col; int e;} exp_t;
  exp_t q1[$], q3[$];
  exp_t e1, e3;

  int SZ[20] = '{69, 60, 53, 48, 43, 39, 36, 33, 31, 29, 27, 26, 24, 23, 22, 21, 20, 19, 18, 17};
  int BB[20];

  int m_committed, m_cx, m_cy, m_zone, m_pending, m_sx, m_sy, m_sz, m_busy, m_rb, m_py, m_py_vld;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  depth_sprite #(.ROM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .x_loc(x_loc), .y_loc(y_loc), .z_loc(z_loc), .loc_valid(loc_valid),
    .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .rom_addr(addr1), .rom_data(rd1), .color(col1), .color_valid(cv1), .busy(busy1));

  depth_sprite #(.ROM_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .x_loc(x_loc), .y_loc(y_loc), .z_loc(z_loc), .loc_valid(loc_valid),
    .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .rom_addr(addr3), .rom_data(rd3), .color(col3), .color_valid(cv3), .busy(busy3));

  function automatic logic [23:0] rom_f(logic [15:0] a);
    logic [15:0] m;
    logic [7:0]  g;
    m = a * 16'd37 + (a >> 8);
    g = m[7:0];
    return {a[7:0] ^ 8'hA5, g, ~a[7:0]};
  endfunction

  always @(posedge clk) begin
    rd1 <= rom_f(addr1);
    r3a <= rom_f(addr3);
    r3b <= r3a;
    r3c <= r3b;
  end
  assign rd3 = r3c;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cv1) begin
      if (q1.size() == 0) chk("unexpected_valid_l1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("color_l1", col1, e1.col);
        chk("latency_l1", cyc - e1.e, 2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cv3) begin
      if (q3.size() == 0) chk("unexpected_valid_l3", 1, 0);
      else begin
        e3 = q3.pop_front();
        chk("color_l3", col3, e3.col);
        chk("latency_l3", cyc - e3.e, 4);
      end
    end
  end

  task automatic model_reset();
    m_committed = 0; m_cx = 0; m_cy = 0; m_zone = 0; m_pending = 0;
    m_sx = 0; m_sy = 0; m_sz = 0; m_busy = 0; m_rb = 0; m_py = 0; m_py_vld = 0;
  endtask

  // Apply the current inputs for one clock, predicting the result from the sprite rules.
  task automatic step();
    int s, left, top, px, py, nb, ea;
    bit ins;
    logic [23:0] d;
    exp_t e;
    s = SZ[m_zone]; left = m_cx - s / 2; top = m_cy - s / 2;
    px = int'(pixel_x); py = int'(pixel_y);
    ins = pixel_valid && (m_committed != 0) && px >= left && px < left + s && py >= top && py < top + s;
    nb = m_rb;
    if (pixel_valid && (m_py_vld == 0 || py != m_py))
      nb = (py > top && py < top + s) ? ((m_rb + s) & 'hFFFF) : BB[m_zone];
    ea = ins ? ((nb + px - left) & 'hFFFF) : BB[m_zone];
    m_rb = nb;
    if (pixel_valid) begin
      m_py = py; m_py_vld = 1;
      d = rom_f(16'(ea));
      e.col = (ins && d[15:8] >= 8'h90) ? d : 24'h0;
      e.e = cyc + 1;
      q1.push_back(e);
      q3.push_back(e);
    end
    if (frame_start && m_pending != 0 && m_busy == 0) begin
      m_cx = m_sx; m_cy = m_sy; m_zone = m_sz; m_committed = 1; m_pending = 0;
    end
    if (m_busy > 0) m_busy--;
    if (loc_valid) begin
      m_sx = int'(x_loc); m_sy = int'(y_loc);
      m_sz = (int'(z_loc) / 50 > 19) ? 19 : int'(z_loc) / 50;
      m_pending = 1; m_busy = m_sz + 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rom_addr_l1", addr1, ea);
    chk("rom_addr_l3", addr3, ea);
    chk("busy", busy1, m_busy > 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; pixel_valid = 1'b0; loc_valid = 1'b0; frame_start = 1'b0;
    #1;
    chk("rst_color_l1", col1, 0); chk("rst_cvalid_l1", cv1, 0);
    chk("rst_color_l3", col3, 0); chk("rst_cvalid_l3", cv3, 0);
    chk("rst_busy", busy1, 0);    chk("rst_addr", addr1, 0);
    q1.delete(); q3.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(int x, int y, int z);
    x_loc = 16'(x); y_loc = 16'(y); z_loc = 16'(z);
    loc_valid = 1'b1; step(); loc_valid = 1'b0;
    repeat (22) step();
  endtask

  task automatic frame();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  task automatic scan(int y0, int y1, int x0, int x1,
                      int tx0, int ty0, int tv0, int tx1, int ty1, int tv1);
    for (int y = (y0 < 0 ? 0 : y0); y <= y1; y++) begin
      for (int x = (x0 < 0 ? 0 : x0); x <= x1; x++) begin
        pixel_x = 16'(x); pixel_y = 16'(y);
        if ($urandom_range(0, 15) == 0) begin
          pixel_valid = 1'b0; step();
        end
        pixel_valid = 1'b1; step();
        if (x == tx0 && y == ty0) chk("target0_addr", addr1, tv0);
        if (x == tx1 && y == ty1) chk("target1_addr", addr1, tv1);
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic scan_box();
    int s, l, t;
    s = SZ[m_zone]; l = m_cx - s / 2; t = m_cy - s / 2;
    scan(t - 1, t + s, l - 2, l + s + 1, -9, -9, 0, -9, -9, 0);
  endtask

  initial begin
    int n, rx, ry, s, l, t;
    BB[0] = 0;
    for (int i = 1; i < 20; i++) BB[i] = BB[i-1] + SZ[i-1] * SZ[i-1];
    model_reset();
    @(negedge clk);
    do_reset();

    load(320, 240, 0);
    frame();
    scan(204, 276, 283, 357, 286, 206, 0, 286, 207, 69);

    rx = $urandom_range(100, 600); ry = $urandom_range(50, 400);
    x_loc = 16'(rx); y_loc = 16'(ry); z_loc = 16'd975;
    loc_valid = 1'b1; step(); loc_valid = 1'b0;
    n = 0;
    repeat (25) begin
      if (busy1) n++;
      step();
    end
    chk("busy_cycles_z975", n, 20);
    frame();
    scan(ry - 9, ry + 9, rx - 10, rx + 9, rx - 8, ry - 8, 25551, -9, -9, 0);

    load($urandom_range(100, 600), $urandom_range(50, 400), 120);
    scan_box();
    frame();
    scan_box();

    load(10, 10, 0);
    frame();
    scan(0, 50, 0, 50, 45, 10, 0, -9, -9, 0);

    for (int it = 0; it < 4; it++) begin
      x_loc = 16'($urandom_range(40, 600)); y_loc = 16'($urandom_range(40, 400));
      z_loc = 16'($urandom_range(0, 1100));
      loc_valid = 1'b1; step(); loc_valid = 1'b0;
      frame();
      repeat (22) step();
      x_loc = 16'($urandom_range(40, 600)); y_loc = 16'($urandom_range(40, 400));
      z_loc = 16'($urandom_range(0, 1100));
      loc_valid = 1'b1; frame_start = 1'b1; step(); loc_valid = 1'b0; frame_start = 1'b0;
      scan_box();
    end

    s = SZ[m_zone]; l = m_cx - s / 2; t = m_cy - s / 2;
    scan(t + 2, t + 3, l, l + s - 1, -9, -9, 0, -9, -9, 0);
    do_reset();
    scan(t, t + 6, l, l + s - 1, -9, -9, 0, -9, -9, 0);
    load(100, 100, 975);
    frame();
    scan_box();

    pixel_valid = 1'b0;
    repeat (8) step();
    chk("drained_l1", q1.size(), 0);
    chk("drained_l3", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
